cordic_req_arbiter: RTL
=======================

Name: cordic_req_arbiter

Overview:
Shares one CORDIC arctan/magnitude engine between NREQ requesters. A round-robin policy selects one pending request. The block latches that request's operands and function code, pulses the engine start, and waits for the engine's done. It then returns the 32-bit result to the granted requester with a one-cycle ack. It sits between the client blocks and the single engine instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDXW, 2, width of granted-index field, equals ceil(log2(NREQ))
TIMEOUT_CYC, 64, maximum WAIT cycles before abort; used only when the optional feature is compiled in

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req  in  NREQ  per-requester request level; held high until that requester's ack
req_x  in  16*NREQ  packed x operands; requester k uses bits [16k+15:16k]
req_y  in  16*NREQ  packed y operands, same packing as req_x
req_func  in  4*NREQ  packed function codes (0 = arctan, 1 = magnitude)
ack  out  NREQ  one-hot one-cycle pulse; resp_data is valid in the same cycle
resp_data  out  32  result for the acked requester
resp_err  out  1  timeout flag, qualified by ack
busy  out  1  high in every state except IDLE
grant_idx  out  IDXW  index of the current or last granted requester
eng_st  out  1  engine start, one-cycle pulse
eng_x  out  16  latched x operand
eng_y  out  16  latched y operand
eng_func  out  4  latched function code, held stable through RESP
eng_done  in  1  engine done level; stays high until the next start
eng_result  in  32  engine result, valid while eng_done is high

Behaviour:
- Reset:
  - state = IDLE; ack = 0; eng_st = 0; resp_data = 0; resp_err = 0.
  - eng_x, eng_y, eng_func = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority. grant_idx = NREQ-1.
  - Reset asserted mid-operation aborts the operation immediately. No ack is issued. The engine may finish unobserved.
- IDLE:
  - If req != 0, select the first set bit scanning from last+1 upward, wrapping modulo NREQ.
  - Latch that requester's x, y and func into eng_x, eng_y, eng_func. Set grant_idx to the selected index.
  - Next state is ISSUE. Requests are sampled only in IDLE.
- ISSUE: eng_st = 1 for exactly this one cycle. Clear the armed flag. Next state is WAIT.
- WAIT:
  - The armed flag sets the first cycle eng_done is sampled low. This rejects a done left high by the previous operation.
  - When armed and eng_done = 1, capture eng_result into resp_data and go to RESP.
- RESP:
  - ack[grant_idx] = 1 for one cycle; all other ack bits stay 0.
  - last = grant_idx. Next state is IDLE.
  - Minimum req-to-ack latency = 3 cycles + engine latency.
- Fairness: with all requests continuously high, grants cycle 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 other operations.
- A requester that drops req after grant still receives its ack. The result is discarded by the requester, and the arbiter needs no special handling.
- Back-to-back: ack and the next IDLE selection never share a cycle. The acked requester must drop req on the cycle after ack or it is re-eligible, at lowest priority.
- eng_x, eng_y and eng_func change only in IDLE on a selection.

Optional Feature:
CORDIC_ARB_TIMEOUT_EN:
- Defined: an 8-bit-minimum WAIT-cycle counter is cleared in ISSUE.
  - If it reaches TIMEOUT_CYC without an armed done, go to RESP with resp_data = 0 and resp_err = 1.
  - A normal completion gives resp_err = 0.
- Undefined: no counter, resp_err is tied 0, and WAIT lasts indefinitely.

Test Plan:
- Reset, then req = 4'b0001, x = 16'h1000, y = 16'h1000, func = 0, with an engine model giving done after 20 cycles and result 32'h0000_3244 -> eng_st single pulse, ack = 4'b0001 with resp_data = 32'h0000_3244, busy low afterwards.
- req = 4'b1111 held, each requester dropping req after its ack -> grant order 0,1,2,3 with exactly one ack per requester.
- Engine model holds eng_done = 1 from the previous op through ISSUE and the first WAIT cycle -> no early capture; ack only after done goes low then high again.
- rst asserted during WAIT of requester 2 -> ack stays 0, state IDLE, the next req = 4'b0100 is granted first, with last = 3.
- Timeout test, built with CORDIC_ARB_TIMEOUT_EN and TIMEOUT_CYC = 64, engine never asserts done -> ack after 64 WAIT cycles with resp_err = 1 and resp_data = 0.
- Timeout absence, built without the macro, engine done delayed 200 cycles -> correct result and resp_err = 0.

Source files
------------

// File: rtl/cordic_req_arbiter.sv
// Round-robin arbiter that shares one CORDIC engine among NREQ requesters.
// Optional WAIT-state timeout is compiled in with `define CORDIC_ARB_TIMEOUT_EN.
module cordic_req_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned IDXW        = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  input  logic [4*NREQ-1:0]    req_func,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic                 busy,
  output logic [IDXW-1:0]      grant_idx,
  output logic                 eng_st,
  output logic [15:0]          eng_x,
  output logic [15:0]          eng_y,
  output logic [3:0]           eng_func,
  input  logic                 eng_done,
  input  logic [31:0]          eng_result
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] last;
  logic            armed;
  logic            sel_found;
  logic [IDXW-1:0] sel_idx;
  logic            done_ok;

  assign done_ok = (state == WAIT) && armed && eng_done;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int unsigned CNTW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNTW-1:0] wait_cnt;
  logic            tmo_hit;

  assign tmo_hit = (state == WAIT) && (wait_cnt == CNTW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // An armed done wins over a timeout landing on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err <= 1'b0;
    end else if (done_ok) begin
      resp_err <= 1'b0;
    end else if (tmo_hit) begin
      resp_err <= 1'b1;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  // Scan from last+1 upward, wrapping, so the previous winner has lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = last;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      int unsigned k;
      k = (32'(last) + i) % NREQ;
      if (!sel_found && req[k]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(k);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (sel_found) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (done_ok) state_nxt = RESP;
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (tmo_hit) state_nxt = RESP;
`endif
      end
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IDXW'(NREQ - 1);
      grant_idx <= IDXW'(NREQ - 1);
      eng_x     <= '0;
      eng_y     <= '0;
      eng_func  <= '0;
      resp_data <= '0;
      armed     <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (sel_found) begin
            grant_idx <= sel_idx;
            eng_x     <= req_x[16*sel_idx +: 16];
            eng_y     <= req_y[16*sel_idx +: 16];
            eng_func  <= req_func[4*sel_idx +: 4];
          end
        end
        ISSUE: armed <= 1'b0;
        WAIT: begin
          // A done still high from the previous operation is ignored until seen low.
          if (!armed && !eng_done) armed <= 1'b1;
          if (done_ok) begin
            resp_data <= eng_result;
          end
`ifdef CORDIC_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            resp_data <= '0;
          end
`endif
        end
        RESP: last <= grant_idx;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (state == RESP) ack[grant_idx] = 1'b1;
  end

  assign eng_st = (state == ISSUE);
  assign busy   = (state != IDLE);

endmodule
